pc_sequencer: RTL and testbench

Next-PC controller for the 8-bit CPU's instruction fetch path. Each cycle it selects the 15-bit program counter from one of five sources: increment, jump, call, return, or interrupt vector. It owns an internal hardware return-address stack and a single maskable interrupt input. The ROM fetch address is driven from its registered PC output, and the decoded instruction's control strobes feed back into it.

---
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: selects the fetch address from increment, jump, call,
// return or interrupt vector, and owns a register-based return-address stack.
module pc_sequencer #(
  parameter int          DEPTH  = 8,
  parameter logic [14:0] VECTOR = 15'h0004
) (
  input  logic                       CLK,
  input  logic                       nRESET,
  input  logic                       STALL,
  input  logic                       JUMP,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic                       RETI,
  input  logic [14:0]                JADDR,
  input  logic                       EI,
  input  logic                       DI,
  input  logic                       IRQ,
  output logic [14:0]                PC,
  output logic [$clog2(DEPTH):0]     SP,
  output logic                       IE,
  output logic                       IACK,
  output logic                       OVF,
  output logic                       UNF,
  output logic                       FAULT
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] FULL = SPW'(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    INT   = 2'd1,
    FLT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [14:0]      pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             ie_q, ie_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [14:0]      stack_q [DEPTH];

  logic             push_en;
  logic [14:0]      push_data;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [14:0]      pc_inc;

  assign wr_idx = sp_q[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign pc_inc = pc_q + 15'd1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    ie_d      = ie_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push_en   = 1'b0;
    push_data = pc_inc;

    unique case (state_q)
      RUN: begin
        if (!STALL) begin
          // A pending interrupt aborts the current instruction outright.
          if (IRQ && ie_q) begin
            state_d = INT;
          end else begin
            if (RETI || RET) begin
              if (sp_q == '0) begin
                unf_d   = 1'b1;
                state_d = FLT;
              end else begin
                pc_d = stack_q[rd_idx];
                sp_d = sp_q - SPW'(1);
                if (RETI) ie_d = 1'b1;
              end
            end else if (CALL) begin
              if (sp_q == FULL) begin
                ovf_d   = 1'b1;
                state_d = FLT;
              end else begin
                push_en   = 1'b1;
                push_data = pc_inc;
                sp_d      = sp_q + SPW'(1);
                pc_d      = JADDR;
              end
            end else if (JUMP) begin
              pc_d = JADDR;
            end else begin
              pc_d = pc_inc;
            end
            if (EI) ie_d = 1'b1;
            if (DI) ie_d = 1'b0;
          end
        end
      end
      INT: begin
        if (!STALL) begin
          if (sp_q == FULL) begin
            ovf_d   = 1'b1;
            state_d = FLT;
          end else begin
            push_en   = 1'b1;
            push_data = pc_q;
            sp_d      = sp_q + SPW'(1);
            pc_d      = VECTOR;
            ie_d      = 1'b0;
            state_d   = RUN;
          end
        end
      end
      FLT: begin
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= RUN;
      pc_q    <= '0;
      sp_q    <= '0;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents carry no reset; only the occupancy counter is cleared.
  always_ff @(posedge CLK) begin
    if (push_en) stack_q[wr_idx] <= push_data;
  end

  assign PC    = pc_q;
  assign SP    = sp_q;
  assign IE    = ie_q;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;
  assign IACK  = (state_q == INT);
  assign FAULT = (state_q == FLT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int          DEPTH  = 8;
  localparam logic [14:0] VECTOR = 15'h0004;

  logic        CLK;
  logic        nRESET;
  logic        STALL, JUMP, CALL, RET, RETI, EI, DI, IRQ;
  logic [14:0] JADDR;
  logic [14:0] PC;
  logic [3:0]  SP;
  logic        IE, IACK, OVF, UNF, FAULT;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model: the stack is a plain queue, mode 0=run 1=int 2=fault.
  int          mPc;
  int          mStack[$];
  bit          mIe, mOvf, mUnf;
  int          mMode;

  pc_sequencer #(.DEPTH(DEPTH), .VECTOR(VECTOR)) dut (
    .CLK(CLK), .nRESET(nRESET), .STALL(STALL), .JUMP(JUMP), .CALL(CALL),
    .RET(RET), .RETI(RETI), .JADDR(JADDR), .EI(EI), .DI(DI), .IRQ(IRQ),
    .PC(PC), .SP(SP), .IE(IE), .IACK(IACK), .OVF(OVF), .UNF(UNF),
    .FAULT(FAULT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("pc", 32'(PC), 32'(mPc));
    checkOutput("sp", 32'(SP), 32'(mStack.size()));
    checkOutput("ie", 32'(IE), 32'(mIe));
    checkOutput("iack", 32'(IACK), 32'(mMode == 1));
    checkOutput("ovf", 32'(OVF), 32'(mOvf));
    checkOutput("unf", 32'(UNF), 32'(mUnf));
    checkOutput("fault", 32'(FAULT), 32'(mMode == 2));
  endtask

  task automatic clearInputs();
    STALL = 0; JUMP = 0; CALL = 0; RET = 0; RETI = 0;
    EI = 0; DI = 0; IRQ = 0; JADDR = '0;
  endtask

  task automatic modelUpdate();
    bit newIe;
    if (mMode == 2 || STALL) return;
    if (mMode == 1) begin
      if (mStack.size() == DEPTH) begin
        mOvf = 1; mMode = 2;
      end else begin
        mStack.push_back(mPc);
        mPc = int'(VECTOR); mIe = 0; mMode = 0;
      end
      return;
    end
    if (IRQ && mIe) begin
      mMode = 1;
      return;
    end
    newIe = mIe;
    if (RET || RETI) begin
      if (mStack.size() == 0) begin
        mUnf = 1; mMode = 2;
      end else begin
        mPc = mStack.pop_back();
        if (RETI) newIe = 1;
      end
    end else if (CALL) begin
      if (mStack.size() == DEPTH) begin
        mOvf = 1; mMode = 2;
      end else begin
        mStack.push_back((mPc + 1) % 32768);
        mPc = int'(JADDR);
      end
    end else if (JUMP) begin
      mPc = int'(JADDR);
    end else begin
      mPc = (mPc + 1) % 32768;
    end
    if (EI) newIe = 1;
    if (DI) newIe = 0;
    mIe = newIe;
  endtask

  // One clock: inputs already driven, model follows the edge, outputs checked 1ns later.
  task automatic applyStimulus();
    @(posedge CLK);
    modelUpdate();
    #1;
    compareAll();
  endtask

  task automatic doReset();
    clearInputs();
    #2;
    nRESET = 1'b0;
    mPc = 0; mStack.delete(); mIe = 0; mOvf = 0; mUnf = 0; mMode = 0;
    #1;
    compareAll();
    @(negedge CLK);
    nRESET = 1'b1;
  endtask

  initial begin
    nRESET = 1'b1;
    clearInputs();
    mPc = 0; mIe = 0; mOvf = 0; mUnf = 0; mMode = 0;
    @(negedge CLK);

    // Reset and increment
    doReset();
    checkOutput("rstPc", 32'(PC), 32'h0);
    for (int i = 1; i < 5; i++) begin
      applyStimulus();
      checkOutput("incPc", 32'(PC), 32'(i));
    end
    JUMP = 1; JADDR = 15'h7FFF;
    applyStimulus();
    checkOutput("jmpMax", 32'(PC), 32'h7FFF);
    clearInputs();
    applyStimulus();
    checkOutput("wrapPc", 32'(PC), 32'h0);

    // Call and return
    JUMP = 1; JADDR = 15'h0010;
    applyStimulus();
    clearInputs(); CALL = 1; JADDR = 15'h0200;
    applyStimulus();
    checkOutput("callPc", 32'(PC), 32'h200);
    checkOutput("callSp", 32'(SP), 32'd1);
    clearInputs(); RET = 1;
    applyStimulus();
    checkOutput("retPc", 32'(PC), 32'h11);
    checkOutput("retSp", 32'(SP), 32'd0);

    // Interrupt entry and exit with a jump that must be discarded
    clearInputs(); EI = 1;
    applyStimulus();
    clearInputs(); JUMP = 1; JADDR = 15'h0030;
    applyStimulus();
    IRQ = 1; JADDR = 15'h0123;
    applyStimulus();
    checkOutput("intIack", 32'(IACK), 32'd1);
    checkOutput("intPc", 32'(PC), 32'h30);
    IRQ = 0;
    applyStimulus();
    checkOutput("vecPc", 32'(PC), 32'(VECTOR));
    checkOutput("vecIe", 32'(IE), 32'd0);
    checkOutput("vecSp", 32'(SP), 32'd1);
    checkOutput("vecIack", 32'(IACK), 32'd0);
    clearInputs(); RETI = 1;
    applyStimulus();
    checkOutput("retiPc", 32'(PC), 32'h30);
    checkOutput("retiIe", 32'(IE), 32'd1);

    // Stall holds a pending call
    clearInputs(); STALL = 1; CALL = 1; JADDR = 15'h0300;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("stallPc", 32'(PC), 32'h30);
      checkOutput("stallSp", 32'(SP), 32'd0);
    end
    STALL = 0;
    applyStimulus();
    checkOutput("unstallPc", 32'(PC), 32'h300);
    checkOutput("unstallSp", 32'(SP), 32'd1);

    // Stall during INT keeps IACK, then async reset in the middle of INT
    clearInputs(); IRQ = 1;
    applyStimulus();
    IRQ = 0; STALL = 1;
    applyStimulus();
    checkOutput("intStallIack", 32'(IACK), 32'd1);
    doReset();
    checkOutput("rstIack", 32'(IACK), 32'd0);
    checkOutput("rstPc2", 32'(PC), 32'h0);

    // Overflow
    for (int i = 0; i < DEPTH; i++) begin
      clearInputs(); CALL = 1; JADDR = 15'(16'h0040 + i);
      applyStimulus();
    end
    checkOutput("fullSp", 32'(SP), 32'd8);
    JADDR = 15'h0555;
    applyStimulus();
    checkOutput("ovfFlag", 32'(OVF), 32'd1);
    checkOutput("ovfFault", 32'(FAULT), 32'd1);
    checkOutput("ovfPc", 32'(PC), 32'h47);
    for (int i = 0; i < 4; i++) begin
      clearInputs(); EI = 1; IRQ = 1; JUMP = 1; RET = (i % 2 == 0);
      STALL = (i == 3); JADDR = 15'h0777;
      applyStimulus();
      checkOutput("frozenPc", 32'(PC), 32'h47);
      checkOutput("frozenSp", 32'(SP), 32'd8);
    end

    // Underflow
    doReset();
    RET = 1;
    applyStimulus();
    checkOutput("unfFlag", 32'(UNF), 32'd1);
    checkOutput("unfFault", 32'(FAULT), 32'd1);
    checkOutput("unfPc", 32'(PC), 32'h0);

    // Priority: pop beats jump, DI beats EI
    doReset();
    CALL = 1; JADDR = 15'h0050;
    applyStimulus();
    clearInputs(); RET = 1; JUMP = 1; JADDR = 15'h0077;
    applyStimulus();
    checkOutput("popWinsPc", 32'(PC), 32'h1);
    checkOutput("popWinsSp", 32'(SP), 32'd0);
    clearInputs(); EI = 1;
    applyStimulus();
    EI = 1; DI = 1;
    applyStimulus();
    checkOutput("diWins", 32'(IE), 32'd0);

    // Randomized traffic against the model
    for (int burst = 0; burst < 8; burst++) begin
      doReset();
      for (int cyc = 0; cyc < 250; cyc++) begin
        STALL = ($urandom_range(7) == 0);
        JUMP  = ($urandom_range(3) == 0);
        CALL  = ($urandom_range(5) == 0);
        RET   = ($urandom_range(7) == 0);
        RETI  = ($urandom_range(15) == 0);
        EI    = ($urandom_range(5) == 0);
        DI    = ($urandom_range(9) == 0);
        IRQ   = ($urandom_range(5) == 0);
        JADDR = 15'($urandom);
        applyStimulus();
        if (mMode == 2 && $urandom_range(3) == 0) doReset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
